// File: rtl/draw_pkg.sv
// Shared types and constants for the draw-region pair reader.
package draw_pkg;

  localparam int DRAW_PAIR_START = 6656;
  localparam int DRAW_PAIR_END   = 6784;
  localparam int DRAW_DATA_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } draw_rd_state_e;

  // One RAM read returns an even word (a) and the following odd word (b).
  typedef struct packed {
    logic [DRAW_DATA_W-1:0] a;
    logic [DRAW_DATA_W-1:0] b;
  } pix_pair_t;

endpackage

// File: rtl/draw_pair_reader_if.sv
// Framebuffer read ports plus the outgoing pixel stream of draw_pair_reader.
interface draw_pair_reader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) ();

  logic              rd_en;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_last;

  // Reader side: drives the RAM address strobes and the stream.
  modport master (
    output rd_en, addr_a, addr_b, pix_data, pix_valid, pix_last,
    input  rdata_a, rdata_b, pix_ready
  );

  // Environment side: RAM read data and stream consumer.
  modport slave (
    input  rd_en, addr_a, addr_b, pix_data, pix_valid, pix_last,
    output rdata_a, rdata_b, pix_ready
  );

endinterface

// File: rtl/draw_pair_fifo.sv
// Two-entry FIFO of returned {a, b} pixel pairs.
module draw_pair_fifo
  import draw_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  pix_pair_t  wdata,
  output pix_pair_t  rdata,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  pix_pair_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  // Push is refused only when full and nothing leaves in the same cycle.
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    full    = (cnt == 2'd2);
    empty   = (cnt == 2'd0);
    count   = cnt;
    rdata   = mem[rd_ptr];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/draw_pair_reader.sv
// Reads the draw-region window as even/odd word pairs from a dual-port RAM
// and serializes them into a one-word-per-beat valid/ready stream.
// Optional build macro: DRAW_PAIR_READER_WRAP_EN (continuous passes).
module draw_pair_reader
  import draw_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int PAIR_START = DRAW_PAIR_START,
  parameter int PAIR_END   = DRAW_PAIR_END
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  draw_pair_reader_if.master bus
);

  localparam int PW = ADDR_W - 1;
  localparam logic [PW-1:0] FIRST_PAIR = PW'(PAIR_START);
  localparam logic [PW-1:0] LAST_PAIR  = PW'(PAIR_END - 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(PAIR_END - PAIR_START - 1);

  if (PAIR_END <= PAIR_START) begin : g_range_chk
    $error("draw_pair_reader: PAIR_END must exceed PAIR_START");
  end
  if (DATA_W != DRAW_DATA_W) begin : g_width_chk
    $error("draw_pair_reader: DATA_W must match DRAW_DATA_W");
  end

  draw_rd_state_e state_q, state_d;
  logic [PW-1:0]  pair_q;
  logic [PW-1:0]  pop_idx_q;
  logic           inflight_q;
  logic           sel_q;
  logic           done_q;

  logic           rd_en;
  logic           last_pair;
  logic           beat;
  logic           pop;
  logic           last_beat;
  logic           credit_ok;
  pix_pair_t      wdata;
  pix_pair_t      head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [1:0]     fifo_count;

  draw_pair_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read issue, credit and serializer decode.
  always_comb begin
    credit_ok = !(fifo_full || (fifo_count == 2'd1 && inflight_q));
    rd_en     = (state_q == FETCH) && credit_ok;
    last_pair = (pair_q == LAST_PAIR);
    wdata     = '{a: bus.rdata_a, b: bus.rdata_b};
    beat      = !fifo_empty && bus.pix_ready;
    pop       = beat && sel_q;
    last_beat = pop && (pop_idx_q == LAST_IDX);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH: begin
`ifndef DRAW_PAIR_READER_WRAP_EN
        if (rd_en && last_pair) state_d = DRAIN;
`endif
      end
      DRAIN:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pair counter, in-flight flag, A/B select, pop index and done pulse.
  // The pop index tracks pass position on the output side, so pix_last and
  // done work the same whether or not the fetch side wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_q     <= '0;
      pop_idx_q  <= '0;
      inflight_q <= 1'b0;
      sel_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      done_q     <= last_beat;
      if (state_q == IDLE && start) pair_q <= FIRST_PAIR;
      else if (rd_en)               pair_q <= last_pair ? FIRST_PAIR : pair_q + 1'b1;
      if (beat) sel_q <= ~sel_q;
      if (pop)  pop_idx_q <= (pop_idx_q == LAST_IDX) ? '0 : pop_idx_q + 1'b1;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign bus.rd_en     = rd_en;
  assign bus.addr_a    = rd_en ? {pair_q, 1'b0} : '0;
  assign bus.addr_b    = rd_en ? {pair_q, 1'b1} : '0;
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_empty ? '0 : (sel_q ? head.b : head.a);
  assign bus.pix_last  = !fifo_empty && sel_q && (pop_idx_q == LAST_IDX);

endmodule

// File: tb/tb_draw_pair_reader.sv
// Bench for draw_pair_reader: start-up vector table, then whole passes under
// several ready patterns checked against a beat-index model of the window.
module tb_draw_pair_reader;

  localparam int WIN_BASE = 13312;
  localparam int NPAIRS   = 128;
  localparam int NBEATS   = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  draw_pair_reader_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  draw_pair_reader #(.ADDR_W(14), .DATA_W(8), .PAIR_START(6656), .PAIR_END(6784)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // RAM model: word value is the low address byte; garbage when not reading.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rdata_a <= bus.addr_a[7:0];
      bus.rdata_b <= bus.addr_b[7:0];
    end else begin
      bus.rdata_a <= 8'($urandom);
      bus.rdata_b <= 8'($urandom);
    end
  end

  // Ready patterns: 0 always, 1 toggle, 2 random 30 %, 3 low for 20 valid cycles.
  int ready_mode = 0;
  int hold_cnt = 0;
  bit tgl = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ready_mode != 3) hold_cnt = 0;
    case (ready_mode)
      0: bus.pix_ready = 1'b1;
      1: begin tgl = ~tgl; bus.pix_ready = tgl; end
      2: bus.pix_ready = ($urandom_range(0, 99) < 30);
      default: begin
        if (bus.pix_valid) hold_cnt++;
        bus.pix_ready = (hold_cnt > 20);
      end
    endcase
  end

  // Reference model: beat n of the stream carries (n mod 256), last on 255;
  // read k targets WIN_BASE + 2*(k mod 128); outstanding pairs never exceed 2.
  int   beat = 0;
  int   rd_count = 0;
  int   outstanding = 0;
  int   n_done = 0;
  int   cyc = 0;
  int   beat0_cyc = 0;
  int   last_hs_cyc = 0;
  bit   exp_done = 1'b0;
  bit   stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic prev_last;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      beat = 0; rd_count = 0; outstanding = 0; n_done = 0;
      exp_done = 1'b0; stall_prev = 1'b0;
    end else begin
      if (done || exp_done) chk("done_timing", 32'(done), 32'(exp_done));
      if (done) begin
        n_done++;
`ifndef DRAW_PAIR_READER_WRAP_EN
        chk("busy_with_done", 32'(busy), 0);
`endif
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.pix_valid), 1);
        chk("stall_data", 32'(bus.pix_data), 32'(prev_data));
        chk("stall_last", 32'(bus.pix_last), 32'(prev_last));
      end
      if (bus.rd_en) begin
        chk("rd_credit", 32'(outstanding < 2), 1);
        chk("addr_a", 32'(bus.addr_a), 32'(WIN_BASE + 2 * (rd_count % NPAIRS)));
        chk("addr_b", 32'(bus.addr_b), 32'(WIN_BASE + 2 * (rd_count % NPAIRS) + 1));
        rd_count++;
        outstanding++;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        chk("pix_data", 32'(bus.pix_data), 32'(beat % NBEATS));
        chk("pix_last", 32'(bus.pix_last), 32'(beat % NBEATS == NBEATS - 1));
        if (beat == 0) beat0_cyc = cyc;
        last_hs_cyc = cyc;
        if (beat % 2 == 1) outstanding--;
        exp_done = (beat % NBEATS == NBEATS - 1);
        beat++;
      end else begin
        exp_done = 1'b0;
      end
      stall_prev = bus.pix_valid && !bus.pix_ready;
      prev_data  = bus.pix_data;
      prev_last  = bus.pix_last;
    end
  end

  typedef struct {
    logic       start;
    logic       busy;
    logic       rd_en;
    logic [13:0] addr_a;
    logic       valid;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [8];

  task automatic run_pass(input int mode, input int restart_at, input string nm);
    int b0, d0, n;
    bit fired;
    fired = 1'b0;
    ready_mode = mode;
    @(posedge clk); #1;
    b0 = beat; d0 = n_done; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n_done == d0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (restart_at >= 0 && !fired && (beat - b0) >= restart_at) begin
        start = 1'b1; fired = 1'b1;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk($sformatf("%s_timeout", nm), 32'(n < 4000), 1);
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("%s_beats", nm), 32'(beat - b0), NBEATS);
    chk($sformatf("%s_done_count", nm), 32'(n_done - d0), 1);
    chk($sformatf("%s_busy_after", nm), 32'(busy), 0);
  endtask

  initial begin
    int n, b0, r0, d0;

    vecs[0] = '{start: 1, busy: 0, rd_en: 0, addr_a: 0,     valid: 0, data: 8'h00};
    vecs[1] = '{start: 0, busy: 1, rd_en: 1, addr_a: 13312, valid: 0, data: 8'h00};
    vecs[2] = '{start: 0, busy: 1, rd_en: 1, addr_a: 13314, valid: 0, data: 8'h00};
    vecs[3] = '{start: 0, busy: 1, rd_en: 0, addr_a: 0,     valid: 1, data: 8'h00};
    vecs[4] = '{start: 0, busy: 1, rd_en: 0, addr_a: 0,     valid: 1, data: 8'h01};
    vecs[5] = '{start: 0, busy: 1, rd_en: 1, addr_a: 13316, valid: 1, data: 8'h02};
    vecs[6] = '{start: 0, busy: 1, rd_en: 0, addr_a: 0,     valid: 1, data: 8'h03};
    vecs[7] = '{start: 0, busy: 1, rd_en: 1, addr_a: 13318, valid: 1, data: 8'h04};

    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_addr_a", 32'(bus.addr_a), 0);
    chk("rst_addr_b", 32'(bus.addr_b), 0);
    chk("rst_valid", 32'(bus.pix_valid), 0);
    chk("rst_last", 32'(bus.pix_last), 0);
    chk("rst_data", 32'(bus.pix_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Start-up sequence, ready held high.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start = vecs[i].start;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_rd_en", i), 32'(bus.rd_en), 32'(vecs[i].rd_en));
      if (vecs[i].rd_en) begin
        chk($sformatf("vec%0d_addr_a", i), 32'(bus.addr_a), 32'(vecs[i].addr_a));
        chk($sformatf("vec%0d_addr_b", i), 32'(bus.addr_b), 32'(vecs[i].addr_a) + 1);
      end
      chk($sformatf("vec%0d_valid", i), 32'(bus.pix_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) chk($sformatf("vec%0d_data", i), 32'(bus.pix_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_last", i), 32'(bus.pix_last), 0);
    end

`ifdef DRAW_PAIR_READER_WRAP_EN
    n = 0;
    while (beat < 600 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wrap_timeout", 32'(n < 2000), 1);
    chk("wrap_done_count", 32'(n_done), 2);
    chk("wrap_no_bubble", 32'(last_hs_cyc - beat0_cyc), 599);
    chk("wrap_busy", 32'(busy), 1);
`else
    n = 0;
    while (n_done == 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pass1_timeout", 32'(n < 1000), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("pass1_beats", 32'(beat), NBEATS);
    chk("pass1_done_count", 32'(n_done), 1);
    chk("pass1_no_bubble", 32'(last_hs_cyc - beat0_cyc), NBEATS - 1);
    chk("pass1_busy_after", 32'(busy), 0);

    run_pass(1, -1, "toggle");
    run_pass(2, -1, "rand30");
    run_pass(2, 50, "restart50");

    // Consumer stalls for 20 cycles from the first valid word.
    ready_mode = 3;
    @(posedge clk); #1;
    b0 = beat; r0 = rd_count; d0 = n_done; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (hold_cnt < 20 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("hold_timeout", 32'(n < 100), 1);
    chk("hold_reads", 32'(rd_count - r0), 2);
    chk("hold_rd_en", 32'(bus.rd_en), 0);
    n = 0;
    while (n_done == d0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_pass_timeout", 32'(n < 2000), 1);
    chk("hold_beats", 32'(beat - b0), NBEATS);

    // Reset in the middle of a pass with a read outstanding.
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    b0 = beat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!((beat - b0) >= 100 && bus.rd_en) && n < 1000);
    chk("abort_wait", 32'(n < 1000), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_rd_en", 32'(bus.rd_en), 0);
    chk("abort_valid", 32'(bus.pix_valid), 0);
    chk("abort_last", 32'(bus.pix_last), 0);
    chk("abort_data", 32'(bus.pix_data), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d_valid", i), 32'(bus.pix_valid), 0);
      chk($sformatf("abort_quiet%0d_done", i), 32'(done), 0);
    end
    run_pass(0, -1, "after_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
